// File: rtl/conf_pkg.sv
// ----------------------------------------------------------------------------
// conf_pkg
// Shared types and constants for the password-protected configuration bank.
//   thr_t        : 7-bit threshold value held in dataP / dataQ
//   conf_state_e : access state of the key guard (OPEN / LOCKED)
//   SEL_BIT      : bit of the configuration byte that selects P (1) or Q (0)
//   DEFAULT_KEY  : access key used when the build does not override KEY
// ----------------------------------------------------------------------------
package conf_pkg;

  typedef logic [6:0] thr_t;

  typedef enum logic {
    OPEN   = 1'b0,
    LOCKED = 1'b1
  } conf_state_e;

  localparam int         SEL_BIT     = 7;
  localparam logic [7:0] DEFAULT_KEY = 8'hC0;

endpackage : conf_pkg

// File: rtl/key_guard.sv
// ----------------------------------------------------------------------------
// key_guard
// Qualifies configuration write attempts against the build-time key.
// Optional lockout (macro CONF_LOCKOUT_EN): a saturating counter of
// consecutive bad-key attempts drives an OPEN/LOCKED FSM; once LOCKED every
// attempt is refused until reset_n is asserted.
//
// Ports:
//   clock     in   system clock (lockout build only)
//   reset_n   in   asynchronous active-low reset (lockout build only)
//   request   in   configuration request
//   confirm   in   write confirm; attempt = request & confirm
//   key       in   8-bit access key for the current attempt
//   write_ok  out  this edge carries an accepted write (combinational)
// ----------------------------------------------------------------------------
module key_guard
  import conf_pkg::*;
#(
  parameter logic [7:0] KEY = DEFAULT_KEY
`ifdef CONF_LOCKOUT_EN
  ,
  parameter int MAX_FAIL = 3
`endif
) (
`ifdef CONF_LOCKOUT_EN
  input  logic       clock,
  input  logic       reset_n,
`endif
  input  logic       request,
  input  logic       confirm,
  input  logic [7:0] key,
  output logic       write_ok
);

  logic attempt;
  assign attempt = request & confirm;

`ifdef CONF_LOCKOUT_EN

  localparam int             CNT_W   = $clog2(MAX_FAIL + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_FAIL);

  conf_state_e      state_q, state_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0] fail_cnt_inc;

  assign fail_cnt_inc = fail_cnt_q + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= OPEN;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fail_cnt_d = fail_cnt_q;
    write_ok   = 1'b0;
    if ((state_q == OPEN) && attempt) begin
      // An X or partially-unknown key never satisfies the equality, so it
      // falls into the bad-key branch and counts as a failure.
      if (key == KEY) begin
        write_ok   = 1'b1;
        fail_cnt_d = '0;
      end else begin
        fail_cnt_d = (fail_cnt_q == CNT_MAX) ? fail_cnt_q : fail_cnt_inc;
        // Lock on the same edge that brings the count up to the limit.
        if (fail_cnt_inc == CNT_MAX) begin
          state_d = LOCKED;
        end
      end
    end
  end

`else

  // Without lockout the guard is permanently open: a bad key is ignored.
  always_comb begin
    write_ok = 1'b0;
    if (attempt && (key == KEY)) begin
      write_ok = 1'b1;
    end
  end

`endif

endmodule : key_guard

// File: rtl/configuration_unit.sv
// ----------------------------------------------------------------------------
// configuration_unit
// Password-protected bank holding two 7-bit thresholds, P and Q, read
// continuously by the monitor and alarm logic. A write is accepted only when
// request and confirm are both high and the key matches KEY. Byte format:
// inputData[7] selects the target (1 -> P, 0 -> Q), inputData[6:0] is the
// value. Optional bad-key lockout is enabled with macro CONF_LOCKOUT_EN.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   request    in   configuration request
//   confirm    in   write confirm
//   key        in   8-bit access key
//   inputData  in   configuration byte
//   dataP      out  stored threshold P (registered)
//   dataQ      out  stored threshold Q (registered)
// ----------------------------------------------------------------------------
module configuration_unit
  import conf_pkg::*;
#(
  parameter logic [7:0] KEY     = DEFAULT_KEY,
  parameter thr_t       P_RESET = 7'd0,
  parameter thr_t       Q_RESET = 7'd0
`ifdef CONF_LOCKOUT_EN
  ,
  parameter int         MAX_FAIL = 3
`endif
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       request,
  input  logic       confirm,
  input  logic [7:0] key,
  input  logic [7:0] inputData,
  output logic [6:0] dataP,
  output logic [6:0] dataQ
);

  logic write_ok;
  thr_t data_p_q, data_p_d;
  thr_t data_q_q, data_q_d;
  thr_t wr_value;
  logic wr_sel_p;

  assign wr_value = inputData[SEL_BIT-1:0];
  assign wr_sel_p = inputData[SEL_BIT];

  key_guard #(
    .KEY      (KEY)
`ifdef CONF_LOCKOUT_EN
    ,
    .MAX_FAIL (MAX_FAIL)
`endif
  ) u_key_guard (
`ifdef CONF_LOCKOUT_EN
    .clock    (clock),
    .reset_n  (reset_n),
`endif
    .request  (request),
    .confirm  (confirm),
    .key      (key),
    .write_ok (write_ok)
  );

  // Exactly one register is loaded per accepted write; the other holds.
  always_comb begin
    data_p_d = data_p_q;
    data_q_d = data_q_q;
    if (write_ok) begin
      if (wr_sel_p) begin
        data_p_d = wr_value;
      end else begin
        data_q_d = wr_value;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_p_q <= P_RESET;
      data_q_q <= Q_RESET;
    end else begin
      data_p_q <= data_p_d;
      data_q_q <= data_q_d;
    end
  end

  assign dataP = data_p_q;
  assign dataQ = data_q_q;

endmodule : configuration_unit

// File: tb/tb_configuration_unit.sv
// ----------------------------------------------------------------------------
// tb_configuration_unit
// Directed bench for configuration_unit: linear sequence of writes, rejected
// attempts, asynchronous resets and (when CONF_LOCKOUT_EN is defined) lockout.
// ----------------------------------------------------------------------------
module tb_configuration_unit;

  logic       clock;
  logic       reset_n;
  logic       request;
  logic       confirm;
  logic [7:0] key;
  logic [7:0] inputData;
  logic [6:0] dataP;
  logic [6:0] dataQ;

  int vectors;
  int miscompares;

  logic [6:0] prev_p;
  logic [6:0] prev_q;

  configuration_unit dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .request   (request),
    .confirm   (confirm),
    .key       (key),
    .inputData (inputData),
    .dataP     (dataP),
    .dataQ     (dataQ)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One clock of stimulus. Just before the edge the outputs must still show
  // the previous values (registered, no combinational path); after the edge
  // they must show the hand-computed expectation.
  task automatic apply(input string tag, input logic req, input logic conf,
                       input logic [7:0] k, input logic [7:0] d,
                       input logic [6:0] exp_p, input logic [6:0] exp_q);
    @(negedge clock);
    request   = req;
    confirm   = conf;
    key       = k;
    inputData = d;
    #1;
    check({tag, " pre dataP"}, dataP, prev_p);
    check({tag, " pre dataQ"}, dataQ, prev_q);
    @(posedge clock);
    #1;
    check({tag, " dataP"}, dataP, exp_p);
    check({tag, " dataQ"}, dataQ, exp_q);
    $display("step %-14s req=%b conf=%b key=%h data=%h -> P=%h Q=%h",
             tag, req, conf, k, d, dataP, dataQ);
    prev_p = exp_p;
    prev_q = exp_q;
  endtask

  // Reset asserted partway through a cycle in which a valid write is set up:
  // outputs clear at once and the pending write is discarded.
  task automatic mid_reset(input string tag);
    @(negedge clock);
    request   = 1'b1;
    confirm   = 1'b1;
    key       = 8'hC0;
    inputData = 8'h81;
    #2;
    reset_n = 1'b0;
    #1;
    check({tag, " async dataP"}, dataP, 7'h00);
    check({tag, " async dataQ"}, dataQ, 7'h00);
    @(posedge clock);
    #1;
    check({tag, " hold dataP"}, dataP, 7'h00);
    check({tag, " hold dataQ"}, dataQ, 7'h00);
    $display("step %-14s reset mid-write -> P=%h Q=%h", tag, dataP, dataQ);
    @(negedge clock);
    request = 1'b0;
    confirm = 1'b0;
    reset_n = 1'b1;
    prev_p  = 7'h00;
    prev_q  = 7'h00;
  endtask

  initial begin
    logic [7:0] xkey;
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    request     = 1'b0;
    confirm     = 1'b0;
    key         = 8'h00;
    inputData   = 8'h00;
    prev_p      = 7'h00;
    prev_q      = 7'h00;

    #12;
    check("reset dataP", dataP, 7'h00);
    check("reset dataQ", dataQ, 7'h00);
    @(negedge clock);
    reset_n = 1'b1;

    // Basic writes to each register.
    apply("wr_p_c0",   1, 1, 8'hC0, 8'hC0, 7'h40, 7'h00);
    apply("wr_q_25",   1, 1, 8'hC0, 8'h25, 7'h40, 7'h25);
    // Rejected attempts.
    apply("bad_key",   1, 1, 8'h3C, 8'h85, 7'h40, 7'h25);
    apply("no_conf",   1, 0, 8'hC0, 8'h81, 7'h40, 7'h25);
    apply("no_req",    0, 1, 8'hC0, 8'h81, 7'h40, 7'h25);
    // Unknown key bits: bit 0 is forced 1 so it can never equal C0.
    xkey = 8'bx1xx_xxx1;
    apply("x_key",     1, 1, xkey,  8'h81, 7'h40, 7'h25);
    // Back-to-back writes and value extremes.
    apply("b2b_p_0a",  1, 1, 8'hC0, 8'h8A, 7'h0A, 7'h25);
    apply("b2b_p_11",  1, 1, 8'hC0, 8'h91, 7'h11, 7'h25);
    apply("p_max",     1, 1, 8'hC0, 8'hFF, 7'h7F, 7'h25);
    apply("q_max",     1, 1, 8'hC0, 8'h7F, 7'h7F, 7'h7F);
    apply("q_zero",    1, 1, 8'hC0, 8'h00, 7'h7F, 7'h00);

    // Three consecutive bad keys followed by correct-key writes.
    apply("fail1",     1, 1, 8'h3C, 8'h85, 7'h7F, 7'h00);
    apply("fail2",     1, 1, 8'h00, 8'h85, 7'h7F, 7'h00);
    apply("fail3",     1, 1, 8'hFF, 8'h85, 7'h7F, 7'h00);
`ifdef CONF_LOCKOUT_EN
    apply("locked_p",  1, 1, 8'hC0, 8'h81, 7'h7F, 7'h00);
    apply("locked_q",  1, 1, 8'hC0, 8'h05, 7'h7F, 7'h00);
`else
    apply("open_p",    1, 1, 8'hC0, 8'h81, 7'h01, 7'h00);
    apply("open_q",    1, 1, 8'hC0, 8'h05, 7'h01, 7'h05);
`endif

    // Reset mid-write clears outputs and reopens the guard.
    mid_reset("mid_reset");
    apply("after_rst", 1, 1, 8'hC0, 8'h81, 7'h01, 7'h00);

    // A valid write between bad attempts keeps the guard open.
    apply("cc_bad1",   1, 1, 8'h3C, 8'h85, 7'h01, 7'h00);
    apply("cc_bad2",   1, 1, 8'h3C, 8'h85, 7'h01, 7'h00);
    apply("cc_valid",  1, 1, 8'hC0, 8'h90, 7'h10, 7'h00);
    apply("cc_bad3",   1, 1, 8'h3C, 8'h85, 7'h10, 7'h00);
    apply("cc_bad4",   1, 1, 8'h3C, 8'h85, 7'h10, 7'h00);
    apply("cc_q_0a",   1, 1, 8'hC0, 8'h0A, 7'h10, 7'h0A);

    // Outputs hold with the bus idle.
    apply("idle",      0, 0, 8'h00, 8'h00, 7'h10, 7'h0A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_configuration_unit

// File: doc/configuration_unit.md
Name: configuration_unit

Overview:
- Password-protected configuration register bank for the healthcare monitoring system.
- Holds two 7-bit threshold settings, P and Q, that downstream monitor and alarm logic read continuously.
- A write is accepted only when the supplied 8-bit key matches a build-time key.
- Byte format: inputData[7] selects the target register; inputData[6:0] is the value.

Parameters:
- KEY, 8'hC0, access key compared against the key input.
- P_RESET, 7'd0, reset value of dataP.
- Q_RESET, 7'd0, reset value of dataQ.
- MAX_FAIL, 3, consecutive bad-key attempts that trigger lockout (only used with lockout enabled).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- request  in  1  configuration request; qualifies an access attempt.
- confirm  in  1  write confirm; an attempt is a write only when request and confirm are both 1.
- key  in  8  access key for the current attempt.
- inputData  in  8  configuration byte: [7] = target (1 → P, 0 → Q), [6:0] = value.
- dataP  out  7  stored threshold P.
- dataQ  out  7  stored threshold Q.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (ports clock and reset_n).
- Reset (reset_n = 0, asynchronous):
  - dataP = P_RESET, dataQ = Q_RESET.
  - Fail counter = 0; state = OPEN.
  - Reset mid-write discards the write.
- Attempt: a rising edge with request = 1 and confirm = 1.
  - request = 1 with confirm = 0 is a no-op; it neither counts as a failure nor clears the counter.
  - request = 0 is a no-op.
- Valid write: attempt, key == KEY, state OPEN.
  - inputData[7] = 1: dataP <= inputData[6:0]; dataQ holds.
  - inputData[7] = 0: dataQ <= inputData[6:0]; dataP holds.
  - Exactly one register is written per edge; the fail counter clears.
- Latency: outputs are registered and visible one clock after the sampling edge. No combinational path from inputs to outputs.
- Back-to-back: a write is accepted on every qualifying edge; no handshake gap is required. The same register may be rewritten on consecutive edges, and the last write wins.
- Bad key (attempt, key != KEY): no register change.
- Unknown or X key: any non-exact match is a mismatch; no write.
- Outputs hold their values indefinitely between writes.

Optional Feature:
- Macro: CONF_LOCKOUT_EN.
- Defined:
  - Two-state FSM, OPEN and LOCKED, plus a saturating fail counter of width $clog2(MAX_FAIL+1).
  - Each bad-key attempt in OPEN increments the counter.
  - When the counter reaches MAX_FAIL, the FSM moves to LOCKED on that edge.
  - In LOCKED, all attempts are ignored, including correct keys. Only reset_n returns the FSM to OPEN.
  - A valid write in OPEN clears the counter.
- Undefined:
  - No counter and no LOCKED state; the FSM is permanently OPEN.
  - Bad keys are simply ignored.

Decomposition:
- Shared package conf_pkg:
  - Typedef for the 7-bit threshold value.
  - State enum {OPEN, LOCKED}.
  - Select-bit position constant (7).
  - Default KEY constant.
- Sub-module key_guard is natural: key compare, fail counter and lockout FSM, producing write_ok. The top level holds the two data registers and the target decode.

Test Plan:
- Reset: assert reset_n = 0 mid-cycle → dataP = 0 and dataQ = 0 immediately, without waiting for a clock edge.
- Write both registers: request = confirm = 1, key = 8'hC0.
  - inputData = 8'hC0 at one edge → dataP = 7'h40, dataQ unchanged.
  - Next edge with inputData = 8'h25 → dataQ = 7'h25, dataP stays 7'h40.
- Bad key: key = 8'h3C, inputData = 8'h85 → no change.
- No confirm: request = 1, confirm = 0, correct key, inputData = 8'h81 → no change.
- Lockout (CONF_LOCKOUT_EN defined):
  - Three bad-key attempts, then the correct key with 8'h81 → dataP unchanged.
  - Assert reset_n, then the correct key with 8'h81 → dataP = 7'h01.
- Counter clear (CONF_LOCKOUT_EN defined):
  - Two bad attempts, one valid write, then two bad attempts → not locked.
  - Next valid write of 8'h0A → dataQ = 7'h0A.
